loadstore_ctrl: RTL and testbench

Multi-cycle control unit that sits directly upstream of the load/store datapath (register bank plus data memory). It accepts one 32-bit RV64-style LD or SD instruction per handshake and decodes its fields. It then sequences the datapath's register addresses, 5-bit offset and write enables over a fixed number of cycles, and reports completion or an illegal-instruction error. All datapath-facing outputs are registered (Moore).

---
 rtl/loadstore_pkg.sv | 18 +
 rtl/loadstore_decode.sv | 55 +++++
 rtl/loadstore_ctrl.sv | 168 ++++++++++++++++
 tb/tb_loadstore_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loadstore_pkg.sv
// Shared encodings and types for the load/store control unit.
package loadstore_pkg;

    localparam int ADDR_W = 5;
    localparam int XLEN   = 64;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_D      = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        MEM  = 2'd2,
        WB   = 2'd3
    } state_e;

endpackage

// File: rtl/loadstore_decode.sv
// Combinational field decoder for LD/SD instruction words.
// The datapath reaches only 32 words, so any immediate with bits above 4 set
// is rejected as illegal.
module loadstore_decode
    import loadstore_pkg::*;
(
    input  logic [31:0]       instr,
    output logic              is_ld,
    output logic              is_sd,
    output logic              illegal,
    output logic [ADDR_W-1:0] ra,
    output logic [ADDR_W-1:0] rb,
    output logic [ADDR_W-1:0] rw,
    output logic [ADDR_W-1:0] offset
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       imm_hi_zero_s;

    assign opcode_s      = instr[6:0];
    assign funct3_s      = instr[14:12];
    // imm[11:5] sits in instr[31:25] for both the I and S formats
    assign imm_hi_zero_s = (instr[31:25] == 7'b0000000);

    // Classify the word and extract register/offset fields per format
    always_comb begin
        is_ld   = 1'b0;
        is_sd   = 1'b0;
        ra      = {ADDR_W{1'b0}};
        rb      = {ADDR_W{1'b0}};
        rw      = {ADDR_W{1'b0}};
        offset  = {ADDR_W{1'b0}};
        case (opcode_s)
            OPC_LOAD: begin
                is_ld  = (funct3_s == F3_D) && imm_hi_zero_s;
                rw     = instr[11:7];
                rb     = instr[19:15];
                offset = instr[24:20];
            end
            OPC_STORE: begin
                is_sd  = (funct3_s == F3_D) && imm_hi_zero_s;
                ra     = instr[24:20];
                rb     = instr[19:15];
                offset = instr[11:7];
            end
            default: begin
                is_ld = 1'b0;
                is_sd = 1'b0;
            end
        endcase
        illegal = ~(is_ld | is_sd);
    end

endmodule

// File: rtl/loadstore_ctrl.sv
// Multi-cycle LD/SD sequencer driving register-bank addresses, memory offset
// and write enables. All datapath-facing outputs come straight from flops;
// the next-state logic computes the value each output takes in the next state.
module loadstore_ctrl
    import loadstore_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] Ra,
    output logic [ADDR_W-1:0] Rb,
    output logic [ADDR_W-1:0] Rw,
    output logic              WE_reg,
    output logic              WE_mem,
    output logic [ADDR_W-1:0] OFFSET,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  retired
);

    state_e            state_r,  state_nxt_s;
    logic [ADDR_W-1:0] ra_r,     ra_nxt_s;
    logic [ADDR_W-1:0] rb_r,     rb_nxt_s;
    logic [ADDR_W-1:0] rw_r,     rw_nxt_s;
    logic [ADDR_W-1:0] off_r,    off_nxt_s;
    logic              is_ld_r,  is_ld_nxt_s;
    logic              we_reg_r, we_reg_nxt_s;
    logic              we_mem_r, we_mem_nxt_s;
    logic              done_r,   done_nxt_s;
    logic              err_r,    err_nxt_s;
    logic              retire_s;
    logic [CNT_W-1:0]  retired_r;

    logic              dec_is_ld_s;
    logic              dec_is_sd_s;
    logic              dec_illegal_s;
    logic [ADDR_W-1:0] dec_ra_s;
    logic [ADDR_W-1:0] dec_rb_s;
    logic [ADDR_W-1:0] dec_rw_s;
    logic [ADDR_W-1:0] dec_off_s;

    loadstore_decode u_decode (
        .instr   (instr),
        .is_ld   (dec_is_ld_s),
        .is_sd   (dec_is_sd_s),
        .illegal (dec_illegal_s),
        .ra      (dec_ra_s),
        .rb      (dec_rb_s),
        .rw      (dec_rw_s),
        .offset  (dec_off_s)
    );

    // Next state and next registered outputs; enables and pulses default low
    always_comb begin
        state_nxt_s  = state_r;
        ra_nxt_s     = ra_r;
        rb_nxt_s     = rb_r;
        rw_nxt_s     = rw_r;
        off_nxt_s    = off_r;
        is_ld_nxt_s  = is_ld_r;
        we_reg_nxt_s = 1'b0;
        we_mem_nxt_s = 1'b0;
        done_nxt_s   = 1'b0;
        err_nxt_s    = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (instr_valid) begin
                    // The instruction word is only looked at on this edge
                    state_nxt_s = DEC;
                    ra_nxt_s    = dec_ra_s;
                    rb_nxt_s    = dec_rb_s;
                    rw_nxt_s    = dec_rw_s;
                    off_nxt_s   = dec_off_s;
                    is_ld_nxt_s = dec_is_ld_s & ~dec_is_sd_s;
                    if (dec_illegal_s) begin
                        done_nxt_s = 1'b1;
                        err_nxt_s  = 1'b1;
                    end else begin
                        done_nxt_s = 1'b0;
                        err_nxt_s  = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DEC: begin
                // err_r is only ever high during DEC, marking a rejected word
                if (err_r) begin
                    state_nxt_s = IDLE;
                end else if (is_ld_r) begin
                    state_nxt_s = MEM;
                end else begin
                    state_nxt_s  = MEM;
                    we_mem_nxt_s = 1'b1;
                    done_nxt_s   = 1'b1;
                    retire_s     = 1'b1;
                end
            end
            MEM: begin
                if (is_ld_r) begin
                    state_nxt_s  = WB;
                    we_reg_nxt_s = (rw_r != {ADDR_W{1'b0}});
                    done_nxt_s   = 1'b1;
                    retire_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WB: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, output and retired-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ra_r      <= {ADDR_W{1'b0}};
            rb_r      <= {ADDR_W{1'b0}};
            rw_r      <= {ADDR_W{1'b0}};
            off_r     <= {ADDR_W{1'b0}};
            is_ld_r   <= 1'b0;
            we_reg_r  <= 1'b0;
            we_mem_r  <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            ra_r      <= ra_nxt_s;
            rb_r      <= rb_nxt_s;
            rw_r      <= rw_nxt_s;
            off_r     <= off_nxt_s;
            is_ld_r   <= is_ld_nxt_s;
            we_reg_r  <= we_reg_nxt_s;
            we_mem_r  <= we_mem_nxt_s;
            done_r    <= done_nxt_s;
            err_r     <= err_nxt_s;
            if (retire_s) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Ready is a pure decode of the state flop, held low while in reset
    assign instr_ready = rst_n & (state_r == IDLE);
    assign Ra          = ra_r;
    assign Rb          = rb_r;
    assign Rw          = rw_r;
    assign OFFSET      = off_r;
    assign WE_reg      = we_reg_r;
    assign WE_mem      = we_mem_r;
    assign done        = done_r;
    assign err         = err_r;
    assign retired     = retired_r;

endmodule

// File: tb/tb_loadstore_ctrl.sv
// Self-checking bench for loadstore_ctrl with a behavioural instruction model.
module tb_loadstore_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  Ra, Rb, Rw, OFFSET;
    logic        WE_reg, WE_mem, done, err;
    logic [15:0] retired;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_retired = 16'd0;

    loadstore_ctrl #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .Ra          (Ra),
        .Rb          (Rb),
        .Rw          (Rw),
        .WE_reg      (WE_reg),
        .WE_mem      (WE_mem),
        .OFFSET      (OFFSET),
        .done        (done),
        .err         (err),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit legal;
        bit ld;
        bit sd;
        int ra;
        int rb;
        int rw;
        int off;
        int busy;   // cycles from accept edge until instr_ready returns
    } exp_t;

    // Reference: decode with plain arithmetic on the instruction word
    function automatic exp_t model(input logic [31:0] w);
        exp_t m;
        int opc, f3, rd, rs1, rs2, imm_i, imm_s;
        opc   = int'(w % 128);
        f3    = int'((w / 4096) % 8);
        rd    = int'((w / 128) % 32);
        rs1   = int'((w / 32768) % 32);
        rs2   = int'((w / 1048576) % 32);
        imm_i = int'(w / 1048576);
        imm_s = int'(w / 33554432) * 32 + rd;
        m.ld  = (opc == 3)  && (f3 == 3) && (imm_i < 32);
        m.sd  = (opc == 35) && (f3 == 3) && (imm_s < 32);
        m.legal = m.ld || m.sd;
        m.ra  = m.sd ? rs2 : 0;
        m.rb  = rs1;
        m.rw  = m.ld ? rd : 0;
        m.off = m.ld ? imm_i : imm_s;
        m.busy = m.ld ? 3 : (m.sd ? 2 : 1);
        return m;
    endfunction

    // Offer one instruction at a negedge and check every cycle until ready again
    task automatic run_instr(input logic [31:0] w, input string tag);
        exp_t m;
        int   n;
        logic [4:0]  exp_ctl;
        logic [19:0] exp_fld;
        m = model(w);
        n = 0;
        while (instr_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait actual=%b required=1", tag, instr_ready);
        end
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        for (int k = 1; k <= m.busy + 1; k++) begin
            @(negedge clk);
            exp_ctl = {(k == m.busy + 1), (k == m.busy), (!m.legal && k == m.busy),
                       (m.sd && k == 2), (m.ld && m.rw != 0 && k == 3)};
            checks++;
            if ({instr_ready, done, err, WE_mem, WE_reg} !== exp_ctl) begin
                errors++;
                $display("FAIL %s ctl cyc%0d actual(rdy,done,err,wem,wer)=%b required=%b",
                         tag, k, {instr_ready, done, err, WE_mem, WE_reg}, exp_ctl);
            end
            if (m.legal) begin
                exp_fld = {5'(m.ra), 5'(m.rb), 5'(m.rw), 5'(m.off)};
                checks++;
                if ({Ra, Rb, Rw, OFFSET} !== exp_fld) begin
                    errors++;
                    $display("FAIL %s fields cyc%0d actual Ra=%0d Rb=%0d Rw=%0d OFF=%0d required Ra=%0d Rb=%0d Rw=%0d OFF=%0d",
                             tag, k, Ra, Rb, Rw, OFFSET, m.ra, m.rb, m.rw, m.off);
                end
            end
        end
        if (m.legal) exp_retired = exp_retired + 16'd1;
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("FAIL %s retired actual=%0d required=%0d", tag, retired, exp_retired);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'h0;
        #12;
        checks++;
        if ({Ra, Rb, Rw, OFFSET, WE_reg, WE_mem, done, err, retired} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs actual Ra=%0d Rb=%0d Rw=%0d OFF=%0d wer=%b wem=%b done=%b err=%b ret=%0d required all 0",
                     Ra, Rb, Rw, OFFSET, WE_reg, WE_mem, done, err, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready actual=%b required=1", instr_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_store();
        run_instr(32'h005131A3, "sd_x5_x2_3");
    endtask

    task automatic test_load();
        run_instr(32'h0040B383, "ld_x7_x1_4");
    endtask

    task automatic test_load_x0();
        run_instr(32'h0040B003, "ld_x0");
    endtask

    task automatic test_illegal();
        run_instr(32'h00208033, "ill_add");
        run_instr(32'h0200B383, "ill_ld_imm32");
        run_instr(32'h0220B023, "ill_sd_imm32");
        run_instr(32'h0040A383, "ill_lw_f3");
    endtask

    task automatic test_random();
        logic [4:0]  r1, r2, rd, off;
        logic [6:0]  hi;
        logic [31:0] w;
        for (int i = 0; i < 30; i++) begin
            r1  = 5'($urandom);
            r2  = 5'($urandom);
            rd  = 5'($urandom);
            off = 5'($urandom);
            hi  = 7'($urandom_range(1, 127));
            case ($urandom_range(0, 4))
                0:       w = {7'b0, off, r1, 3'b011, rd, 7'b0000011};
                1:       w = {7'b0, r2, r1, 3'b011, off, 7'b0100011};
                2:       w = {hi, off, r1, 3'b011, rd, 7'b0000011};
                3:       w = {hi, r2, r1, 3'b011, off, 7'b0100011};
                default: w = $urandom;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_instr(w, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        instr       = 32'h005131A3;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr = $urandom;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (instr_ready === 1'b1) break;
            checks++;
            if ({Ra, Rb, Rw, OFFSET} !== {5'd5, 5'd2, 5'd0, 5'd3}) begin
                errors++;
                $display("FAIL b2b_sd_hold cyc%0d actual Ra=%0d Rb=%0d Rw=%0d OFF=%0d required 5 2 0 3",
                         n, Ra, Rb, Rw, OFFSET);
            end
            instr = $urandom;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL b2b_spacing actual=%0d required=3", n);
        end
        instr = 32'h0040B383;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({instr_ready, WE_reg, Ra, Rb, Rw, OFFSET} !==
                {(k == 4), (k == 3), 5'd0, 5'd1, 5'd7, 5'd4}) begin
                errors++;
                $display("FAIL b2b_ld cyc%0d actual rdy=%b wer=%b Ra=%0d Rb=%0d Rw=%0d OFF=%0d required rdy=%b wer=%b 0 1 7 4",
                         k, instr_ready, WE_reg, Ra, Rb, Rw, OFFSET, (k == 4), (k == 3));
            end
        end
        exp_retired = exp_retired + 16'd2;
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("FAIL b2b_retired actual=%0d required=%0d", retired, exp_retired);
        end
    endtask

    task automatic test_reset_abort();
        instr       = 32'h0040B383;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);   // DEC
        @(negedge clk);   // MEM
        checks++;
        if ({WE_reg, done, Rw} !== {1'b0, 1'b0, 5'd7}) begin
            errors++;
            $display("FAIL abort_mem actual wer=%b done=%b Rw=%0d required 0 0 7", WE_reg, done, Rw);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_retired = 16'd0;
        checks++;
        if ({Ra, Rb, Rw, OFFSET, WE_reg, WE_mem, done, err, retired} !== 40'h0) begin
            errors++;
            $display("FAIL abort_outputs actual Ra=%0d Rb=%0d Rw=%0d OFF=%0d wer=%b wem=%b done=%b err=%b ret=%0d required all 0",
                     Ra, Rb, Rw, OFFSET, WE_reg, WE_mem, done, err, retired);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({WE_reg, done} !== 2'b00) begin
                errors++;
                $display("FAIL abort_no_pulse cyc%0d actual wer=%b done=%b required 0 0", k, WE_reg, done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({instr_ready, retired} !== {1'b1, exp_retired}) begin
            errors++;
            $display("FAIL abort_release actual rdy=%b ret=%0d required rdy=1 ret=%0d",
                     instr_ready, retired, exp_retired);
        end
        @(negedge clk);
        run_instr(32'h005131A3, "after_abort_sd");
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_load_x0();
        test_illegal();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
